// File: rtl/line_assembler_pkg.sv
// lc3b_types: shared LC-3b datapath types.
//   lc3b_word        - 16-bit machine word
//   lc3b_line        - 128-bit cache line (eight words, slot k at [16k+15:16k])
//   lc3b_line_idx    - 3-bit word slot within a line
//   lc3b_asm_state_t - line_assembler control state
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_line_idx;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } lc3b_asm_state_t;

  localparam int unsigned WORDS_PER_LINE = 8;

endpackage

// File: rtl/line_assembler.sv
// line_assembler: gathers eight 16-bit words from the memory-side word bus
// into one registered 128-bit line. The first word may land at any slot
// (critical-word-first) and the slot index wraps modulo 8. The first word of
// each fill is also forwarded on crit_word with a one-cycle crit_valid pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begin a fill (sampled only in IDLE)
//   start_idx  in   slot of the critical word
//   in_valid   in   in_word valid
//   in_word    in   incoming word
//   in_ready   out  accepting words (COLLECT)
//   crit_valid out  one-cycle pulse, crit_word valid
//   crit_word  out  first word of the current fill
//   line_valid out  line complete and held (FULL)
//   line       out  assembled line
//   line_ready in   consumer takes the line
//   busy       out  state is not IDLE
module line_assembler
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  lc3b_line_idx start_idx,
  input  logic         in_valid,
  input  lc3b_word     in_word,
  output logic         in_ready,
  output logic         crit_valid,
  output lc3b_word     crit_word,
  output logic         line_valid,
  output lc3b_line     line,
  input  logic         line_ready,
  output logic         busy
);

  lc3b_asm_state_t r_state;
  lc3b_line_idx    r_idx;
  logic [2:0]      r_cnt;
  lc3b_line        r_line;
  lc3b_word        r_crit_word;
  logic            r_crit_valid;
  logic            r_line_valid;

  logic            w_hs;

  // in_ready is a pure state decode, so the handshake never loops back
  // through an input-to-output combinational path.
  assign w_hs = (r_state == COLLECT) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_line       <= '0;
      r_crit_word  <= '0;
      r_crit_valid <= 1'b0;
      r_line_valid <= 1'b0;
    end else begin
      r_crit_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= COLLECT;
            r_idx   <= start_idx;
            r_cnt   <= '0;
          end
        end
        COLLECT: begin
          if (w_hs) begin
            // Slot k lives at bits [16k+15:16k]; idx overflow gives the wrap.
            r_line[{r_idx, 4'b0000} +: 16] <= in_word;
            r_idx <= r_idx + 3'd1;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd0) begin
              r_crit_word  <= in_word;
              r_crit_valid <= 1'b1;
            end
            if (r_cnt == 3'd7) begin
              r_state      <= FULL;
              r_line_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          // start in this cycle is deliberately dropped; requester retries.
          if (line_ready) begin
            r_state      <= IDLE;
            r_line_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_line_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == COLLECT);
  assign busy       = (r_state != IDLE);
  assign line_valid = r_line_valid;
  assign line       = r_line;
  assign crit_valid = r_crit_valid;
  assign crit_word  = r_crit_word;

endmodule

// File: tb/tb_line_assembler.sv
module tb_line_assembler;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   start_idx;
  logic         in_valid;
  logic [15:0]  in_word;
  logic         in_ready;
  logic         crit_valid;
  logic [15:0]  crit_word;
  logic         line_valid;
  logic [127:0] line;
  logic         line_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [15:0]  exp_crit_q [$];
  logic [127:0] exp_line_q [$];
  logic [15:0]  words [8];
  logic         prev_line_valid = 1'b0;

  always #5 clk = ~clk;

  line_assembler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_idx  (start_idx),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .crit_valid (crit_valid),
    .crit_word  (crit_word),
    .line_valid (line_valid),
    .line       (line),
    .line_ready (line_ready),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!reset) begin
      if (crit_valid) begin
        if (exp_crit_q.size() == 0) chk("crit_unexpected", 128'(crit_word), 128'hx);
        else chk("crit_word", 128'(crit_word), 128'(exp_crit_q.pop_front()));
      end
      if (line_valid && !prev_line_valid) begin
        if (exp_line_q.size() == 0) chk("line_unexpected", line, 128'hx);
        else chk("line", line, exp_line_q.pop_front());
      end
    end
    prev_line_valid = line_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one fill from IDLE. bubble toggles in_valid 1,0,1,...; poke_start
  // asserts start throughout COLLECT; hold cycles of line_ready=0 in FULL
  // with junk words and start; start_at_hs asserts start on the release.
  task automatic fill(input string tag, input logic [2:0] idx, input logic [127:0] exp_line,
                      input bit bubble, input bit poke_start, input int hold,
                      input bit start_at_hs, input int exp_edges);
    int n = 0;
    int k = 0;
    exp_crit_q.push_back(words[0]);
    exp_line_q.push_back(exp_line);
    start = 1'b1; start_idx = idx; in_valid = 1'b0; line_ready = 1'b0;
    step();
    start = poke_start;
    start_idx = 3'(idx + 3'd3);
    chk({tag, "_in_ready_t1"}, 128'(in_ready), 128'd1);
    while (k < 8 && n < 40) begin
      in_valid = bubble ? ((n % 2) == 0) : 1'b1;
      in_word  = in_valid ? words[k] : 16'hDEAD;
      if (line_valid !== 1'b0) chk({tag, "_early_line_valid"}, 128'(line_valid), 128'd0);
      step();
      if (in_valid) k++;
      n++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_edges_to_line_valid"}, 128'(n), 128'(exp_edges));
    chk({tag, "_line_valid"}, 128'(line_valid), 128'd1);
    chk({tag, "_in_ready_full"}, 128'(in_ready), 128'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_word = 16'hBEEF; start = 1'b1;
      step();
      chk({tag, "_hold_line"}, line, exp_line);
      chk({tag, "_hold_state"}, {in_ready, line_valid}, 128'b01);
    end
    in_valid = 1'b0;
    start = start_at_hs;
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_released"}, {line_valid, busy, in_ready}, 128'b000);
    step();
    chk({tag, "_still_idle"}, 128'(busy), 128'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_idx = '0; in_valid = 1'b0;
    in_word = '0; line_ready = 1'b0;
    step(); step();
    chk("reset_outputs", {in_ready, crit_valid, line_valid, busy}, 128'd0);
    chk("reset_line", line, 128'd0);
    chk("reset_crit_word", 128'(crit_word), 128'd0);
    reset = 1'b0;
    step();

    // Aligned fill, start poked during COLLECT; 9 cycles counting the start cycle.
    for (int i = 0; i < 8; i++) words[i] = 16'h1000 + 16'(i);
    fill("aligned", 3'd0, 128'h1007_1006_1005_1004_1003_1002_1001_1000, 0, 1, 0, 0, 8);

    // Wrapped fill at slot 5: A..H into slots 5,6,7,0,1,2,3,4.
    words = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 16'hF006, 16'h1007, 16'h2008};
    fill("wrapped", 3'd5, 128'hC003_B002_A001_2008_1007_F006_E005_D004, 0, 0, 0, 1, 8);

    // Bubbles: 8 valid words interleaved with 7 idle cycles carrying junk.
    for (int i = 0; i < 8; i++) words[i] = 16'h3000 + 16'(i);
    fill("bubbles", 3'd0, 128'h3007_3006_3005_3004_3003_3002_3001_3000, 1, 0, 0, 0, 15);

    // Backpressure for 5 cycles, start asserted in the release cycle.
    for (int i = 0; i < 8; i++) words[i] = 16'h4000 + 16'(i);
    fill("backpressure", 3'd3, 128'h4004_4003_4002_4001_4000_4007_4006_4005, 0, 0, 5, 1, 8);

    // Aborted fill: 3 words then reset.
    exp_crit_q.push_back(16'h5000);
    start = 1'b1; start_idx = 3'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_word = 16'h5000 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("abort_outputs", {in_ready, crit_valid, line_valid, busy}, 128'd0);
    chk("abort_line", line, 128'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) words[i] = 16'h2000 + 16'(i);
    fill("after_reset", 3'd2, 128'h2005_2004_2003_2002_2001_2000_2007_2006, 0, 0, 0, 0, 8);

    step(); step();
    chk("crit_queue_drained", 128'(exp_crit_q.size()), 128'd0);
    chk("line_queue_drained", 128'(exp_line_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/line_assembler.md
# line_assembler

Collects a cache line arriving as eight 16-bit words on a narrow valid/ready bus and presents it as one registered 128-bit line to the word-split stage and the cache data array. Supports critical-word-first fills: the first word lands at a caller-chosen slot and the index wraps modulo 8. The first word is also forwarded on a side port so the pipeline can restart before the line completes. Sits between the memory-side word bus and the line-wide datapath.

## Interface
- Parameters: none; widths come from `lc3b_types`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a fill; sampled only in IDLE.
- `start_idx`  in  3  slot of the first word (critical word), 0..7.
- `in_valid`  in  1  `in_word` valid.
- `in_word`  in  16  incoming word.
- `in_ready`  out  1  assembler accepts a word this cycle.
- `crit_valid`  out  1  one-cycle pulse; `crit_word` valid.
- `crit_word`  out  16  first word of the current fill.
- `line_valid`  out  1  `line` complete and held.
- `line`  out  128  assembled line; slot k occupies bits [16k+15:16k].
- `line_ready`  in  1  consumer takes the line.
- `busy`  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=0, `line_valid`=0. `start`=1 goes to COLLECT, loads `idx`=`start_idx`, `cnt`=0.
  - COLLECT: `in_ready`=1. A handshake (`in_valid` and `in_ready`) writes `in_word` into slot `idx`, then `idx`=(`idx`+1) mod 8 (7 wraps to 0) and `cnt`++. The handshake with `cnt`=7 moves to FULL.
  - FULL: `in_ready`=0, `line_valid`=1. `line_ready`=1 returns to IDLE.
- The first accepted word of a fill (`cnt`=0) also loads `crit_word`, and `crit_valid` pulses high for exactly the following cycle.
- Slots not yet written in the current fill keep their previous contents. `line` is only meaningful while `line_valid`=1.
- `start` in COLLECT or FULL is ignored and does not queue.
- `start` in the same cycle as the FULL→IDLE handshake is ignored; the requester must reassert it.
- `in_valid` outside COLLECT is ignored and no data is written.
- `line`, `line_valid`, `crit_word` and `crit_valid` are driven straight from registers; no combinational path from inputs to them.
- `in_ready` and `busy` are decoded from state only; no combinational path from inputs.

## Timing
- Reset: state IDLE, `idx`=0, `cnt`=0, `line`=0, `crit_word`=0. All outputs (`in_ready`, `crit_valid`, `line_valid`, `busy`) are 0.
- Reset in any state discards the partial or held line with no `line_valid` pulse.
- `start` at edge t gives `in_ready`=1 from cycle t+1.
- Throughput: one word per cycle. With `in_valid` held high, a fill takes 8 cycles in COLLECT.
- `line_valid` rises the cycle after the 8th handshake.
- Minimum start-to-`line_valid` latency: 9 cycles.
- The FULL→IDLE handshake takes one cycle, so the next `start` is accepted one cycle later.
- `crit_valid` is high the cycle after the first handshake, concurrent with the second possible handshake.
- `line` holds stable from `line_valid` rise through the handshake cycle.

## Structure
- Add to `lc3b_types` if absent:
  - `lc3b_word` (16 bits).
  - `lc3b_line` (128 bits).
  - `lc3b_line_idx` (3 bits).
  - `enum` `lc3b_asm_state_t` {IDLE, COLLECT, FULL}.
- Single module, no sub-modules.
- Slot write is an indexed part-select on `lc3b_line`. Wrap comes for free from 3-bit `idx` overflow.
- `cnt` is 3 bits; "last word" means `cnt`==7 at the handshake.

## Test plan
- Aligned fill: `start_idx`=0, words 0x1000..0x1007 back-to-back.
  - `line`=0x1007_1006_…_1000, `line_valid` 9 cycles after `start`.
  - `crit_word`=0x1000, `crit_valid` one-cycle pulse.
- Wrapped fill: `start_idx`=5, words A..H. Slots 5,6,7,0,1,2,3,4 hold A..H, and `crit_word`=A.
- Bubbles: `in_valid` toggled 1,0,1,0… 
  - Exactly 8 words captured.
  - `line_valid` only after the 8th handshake.
  - No write on `in_valid`=0 cycles.
- Backpressure: hold `line_ready`=0 for 5 cycles in FULL.
  - `line` stable, `in_ready`=0.
  - Extra `in_valid` words and `start` ignored.
  - Release → IDLE next cycle.
- Reset after 3 words: all outputs 0 next cycle. A new fill with `start_idx`=2 produces a correct line with no stale slots from the aborted fill.
- `start` asserted in COLLECT and in the FULL handshake cycle is ignored: no second fill begins until `start` is reasserted in IDLE.
